// File: rtl/r4_bus_pkg.sv
// Shared definitions for the core's data-memory bus: MMIO register offsets,
// TX_STATUS bit positions, the bus word type and a small decode helper.
package r4_bus_pkg;

  typedef logic [31:0] word_t;

  localparam logic [7:0] OFS_LED     = 8'h00;
  localparam logic [7:0] OFS_CYC_LO  = 8'h04;
  localparam logic [7:0] OFS_CYC_HI  = 8'h08;
  localparam logic [7:0] OFS_TX_DATA = 8'h10;
  localparam logic [7:0] OFS_TX_STAT = 8'h14;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_COUNT_LSB = 8;

  // True when a word-aligned page offset names one of the implemented registers
  function automatic logic isMmioReg(input logic [7:0] ofs);
    return (ofs == OFS_LED)     || (ofs == OFS_CYC_LO)  || (ofs == OFS_CYC_HI) ||
           (ofs == OFS_TX_DATA) || (ofs == OFS_TX_STAT);
  endfunction

endpackage

// File: rtl/dmem_responder_sync_fifo.sv
// Generic synchronous FIFO with an explicit occupancy counter. A push into a
// full FIFO is accepted only when a pop frees a slot in the same cycle; the
// head entry is presented combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         headData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPop;
  logic             doPush;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign doPop    = pop & ~empty;
  assign doPush   = push & (~full | doPop);
  assign headData = mem[rdPtr];

  // Pointers wrap naturally at DEPTH; count tracks occupancy so full/empty are unambiguous
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only accepted pushes outside reset write a slot
  always_ff @(posedge clk) begin
    if (n_reset && doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle core: word RAM plus an MMIO page
// holding the LED register, a 64-bit cycle counter and a byte TX FIFO drained
// by a valid/ready stream. Loads are combinational, stores commit on posedge.
module dmem_responder
  import r4_bus_pkg::*;
#(
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [31:0] dataAddr,
  input  logic [31:0] writeData,
  input  logic        we,
  output logic [31:0] readData,
  output logic [7:0]  led,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        bus_err
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  word_t             ram [RAM_WORDS];
  logic [RAM_AW-1:0] ramIdx;
  logic [7:0]        ofs;
  logic              isRam;
  logic              isPage;
  logic              selLed;
  logic              selTxData;
  logic              selTxStat;
  logic              mapped;
  logic [63:0]       cycleCount;
  logic              overflow;
  logic              fifoPush;
  logic              fifoPop;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [CNT_W-1:0]  fifoCount;
  logic              ovfSet;
  logic              ovfClr;
  word_t             txStatus;

  assign ramIdx    = dataAddr[RAM_AW+1:2];
  assign ofs       = {dataAddr[7:2], 2'b00};
  assign isRam     = (dataAddr < RAM_BYTES);
  assign isPage    = (dataAddr[31:8] == MMIO_BASE[31:8]);
  assign selLed    = isPage && (ofs == OFS_LED);
  assign selTxData = isPage && (ofs == OFS_TX_DATA);
  assign selTxStat = isPage && (ofs == OFS_TX_STAT);
  assign mapped    = isRam || (isPage && isMmioReg(ofs));

  assign fifoPush  = we & selTxData;
  assign fifoPop   = tx_valid & tx_ready;
  assign tx_valid  = ~fifoEmpty;
  assign ovfSet    = fifoPush & fifoFull & ~fifoPop;
  assign ovfClr    = we & selTxStat & writeData[STAT_OVF];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) txFifo (
    .clk      (clk),
    .n_reset  (n_reset),
    .push     (fifoPush),
    .pushData (writeData[7:0]),
    .pop      (fifoPop),
    .headData (tx_data),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  // RAM contents survive reset; stores are still suppressed while reset is held
  always_ff @(posedge clk) begin
    if (n_reset && we && isRam) ram[ramIdx] <= writeData;
  end

  // LED, free-running counter, sticky overflow (set beats clear) and sticky bus error
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      led        <= '0;
      cycleCount <= '0;
      overflow   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      cycleCount <= cycleCount + 64'd1;
      if (we && selLed) led <= writeData[7:0];
      if (ovfSet)      overflow <= 1'b1;
      else if (ovfClr) overflow <= 1'b0;
      if (we && !mapped) bus_err <= 1'b1;
    end
  end

  // Assemble the TX_STATUS word from live FIFO flags and the overflow flag
  always_comb begin
    txStatus                       = '0;
    txStatus[STAT_FULL]            = fifoFull;
    txStatus[STAT_EMPTY]           = fifoEmpty;
    txStatus[STAT_OVF]             = overflow;
    txStatus[STAT_COUNT_LSB +: 8]  = 8'(fifoCount);
  end

  // Zero-latency load mux; unmapped and write-only locations read as zero
  always_comb begin
    readData = '0;
    if (isRam) begin
      readData = ram[ramIdx];
    end else if (isPage) begin
      case (ofs)
        OFS_LED:     readData = {24'h0, led};
        OFS_CYC_LO:  readData = cycleCount[31:0];
        OFS_CYC_HI:  readData = cycleCount[63:32];
        OFS_TX_STAT: readData = txStatus;
        default:     readData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios followed by a
// randomized run, all compared against a queue/array reference model.
module tb_dmem_responder;
  import r4_bus_pkg::*;

  localparam int          DEPTH = 8;
  localparam logic [31:0] MMIO  = 32'h8000_0000;
  localparam logic [31:0] A_LED = MMIO + 32'(OFS_LED);
  localparam logic [31:0] A_CLO = MMIO + 32'(OFS_CYC_LO);
  localparam logic [31:0] A_CHI = MMIO + 32'(OFS_CYC_HI);
  localparam logic [31:0] A_TXD = MMIO + 32'(OFS_TX_DATA);
  localparam logic [31:0] A_STA = MMIO + 32'(OFS_TX_STAT);

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [31:0] dataAddr = '0;
  logic [31:0] writeData = '0;
  logic        we = 1'b0;
  logic [31:0] readData;
  logic [7:0]  led;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        bus_err;

  int assertCount = 0;
  int failCount = 0;

  logic [31:0] mRam [1024];
  logic [7:0]  mLed;
  logic [63:0] mCycle;
  logic [7:0]  mQ [$];
  bit          mOvf;
  bit          mBusErr;

  dmem_responder dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .dataAddr  (dataAddr),
    .writeData (writeData),
    .we        (we),
    .readData  (readData),
    .led       (led),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .bus_err   (bus_err)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit inPage(input logic [31:0] a);
    return a[31:8] == MMIO[31:8];
  endfunction

  function automatic bit modelMapped(input logic [31:0] a);
    return (a < 32'h1000) || (inPage(a) && (a[7:2] inside {6'd0, 6'd1, 6'd2, 6'd4, 6'd5}));
  endfunction

  function automatic logic [31:0] modelStatus();
    logic [31:0] s;
    s = '0;
    s[0] = (mQ.size() == DEPTH);
    s[1] = (mQ.size() == 0);
    s[2] = mOvf;
    s[15:8] = 8'(mQ.size());
    return s;
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if (a < 32'h1000) return mRam[a[11:2]];
    if (inPage(a)) begin
      case (a[7:2])
        6'd0: return {24'h0, mLed};
        6'd1: return mCycle[31:0];
        6'd2: return mCycle[63:32];
        6'd5: return modelStatus();
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  // Drive one bus cycle, clock it, and advance the reference model
  task automatic applyStimulus(input bit rstN, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit rdy);
    bit popNow;
    bit ovfNow;
    n_reset = rstN; we = wr; dataAddr = addr; writeData = wdata; tx_ready = rdy;
    @(posedge clk);
    if (!rstN) begin
      mLed = 8'h0; mCycle = 64'h0; mQ.delete(); mOvf = 1'b0; mBusErr = 1'b0;
    end else begin
      mCycle = mCycle + 64'd1;
      popNow = rdy && (mQ.size() > 0);
      ovfNow = 1'b0;
      if (popNow) void'(mQ.pop_front());
      if (wr && inPage(addr) && addr[7:2] == 6'd4) begin
        if (mQ.size() == DEPTH) ovfNow = 1'b1;
        else mQ.push_back(wdata[7:0]);
      end
      if (ovfNow) mOvf = 1'b1;
      else if (wr && inPage(addr) && addr[7:2] == 6'd5 && wdata[2]) mOvf = 1'b0;
      if (wr && addr < 32'h1000) mRam[addr[11:2]] = wdata;
      if (wr && inPage(addr) && addr[7:2] == 6'd0) mLed = wdata[7:0];
      if (wr && !modelMapped(addr)) mBusErr = 1'b1;
    end
    #1;
    we = 1'b0;
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, ":led"}, 64'(led), 64'(mLed));
    checkOutput({tag, ":bus_err"}, 64'(bus_err), 64'(mBusErr));
    checkOutput({tag, ":tx_valid"}, 64'(tx_valid), 64'(mQ.size() > 0));
    if (mQ.size() > 0) checkOutput({tag, ":tx_data"}, 64'(tx_data), 64'(mQ[0]));
  endtask

  task automatic probeRead(input logic [31:0] addr, input string tag);
    dataAddr = addr; we = 1'b0;
    #1;
    checkOutput(tag, 64'(readData), 64'(modelRead(addr)));
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] low;
    low = 32'($urandom_range(0, 3));
    case ($urandom_range(0, 13))
      0, 1, 2: return (32'($urandom_range(0, 15)) << 2) | low;
      3:       return 32'hFFC | low;
      4:       return A_LED | low;
      5:       return A_CLO | low;
      6:       return A_CHI | low;
      7, 8:    return A_TXD | low;
      9:       return A_STA | low;
      10:      return 32'h8000_000C;
      11:      return 32'h8000_0020;
      12:      return 32'h0000_1000;
      default: return 32'h8000_0100;
    endcase
  endfunction

  // Directed scenarios then a randomized run
  initial begin
    logic [7:0] exp4 [8];
    logic [31:0] a;
    bit wr;
    bit rstN;

    applyStimulus(0, 0, 32'h0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 32'h0, 0);
    checkRegs("reset");
    probeRead(A_CLO, "reset:cyc_lo");
    checkOutput("reset:cyc_const", 64'(readData), 64'h0);
    probeRead(A_STA, "reset:status");

    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 32'h0, 32'h0, 0);
    probeRead(A_CLO, "cyc10");
    checkOutput("cyc10_const", 64'(readData), 64'd10);

    applyStimulus(1, 1, 32'h40, 32'hDEAD_BEEF, 0);
    probeRead(32'h40, "ram:0x40");
    checkOutput("ram:0x40_const", 64'(readData), 64'hDEAD_BEEF);
    probeRead(32'h43, "ram:0x43");
    checkOutput("ram:0x43_const", 64'(readData), 64'hDEAD_BEEF);

    applyStimulus(1, 1, A_LED, 32'h1A5, 0);
    checkOutput("led_const", 64'(led), 64'hA5);
    probeRead(A_LED, "led:read");
    checkOutput("led:read_const", 64'(readData), 64'hA5);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, A_TXD, 32'(8'h11 + i), 0);
      checkRegs("fill");
    end
    probeRead(A_STA, "full:status");
    checkOutput("full:status_const", 64'(readData), 64'h0801);
    applyStimulus(1, 1, A_TXD, 32'h99, 0);
    probeRead(A_STA, "ovf:status");
    checkOutput("ovf:status_const", 64'(readData), 64'h0805);
    for (int i = 0; i < 8; i++) begin
      checkOutput("drain:valid", 64'(tx_valid), 64'h1);
      checkOutput("drain:data", 64'(tx_data), 64'(8'h11 + i));
      applyStimulus(1, 0, 32'h0, 32'h0, 1);
    end
    checkOutput("drain:empty_valid", 64'(tx_valid), 64'h0);
    probeRead(A_STA, "drain:status");
    checkOutput("drain:status_const", 64'(readData), 64'h0006);

    applyStimulus(1, 1, 32'h8000_0020, 32'hFFFF_FFFF, 0);
    checkOutput("unmapped:bus_err", 64'(bus_err), 64'h1);
    checkOutput("unmapped:led", 64'(led), 64'hA5);
    probeRead(32'h8000_0020, "unmapped:read");
    checkOutput("unmapped:read_const", 64'(readData), 64'h0);
    probeRead(A_STA, "unmapped:status");
    applyStimulus(1, 1, A_STA, 32'h4, 0);
    probeRead(A_STA, "clr:status");
    checkOutput("clr:status_const", 64'(readData), 64'h0002);
    checkRegs("clr");

    for (int i = 0; i < 8; i++) applyStimulus(1, 1, A_TXD, 32'(8'h21 + i), 0);
    applyStimulus(1, 1, A_TXD, 32'h55, 1);
    probeRead(A_STA, "pushpop:status");
    checkOutput("pushpop:status_const", 64'(readData), 64'h0801);
    exp4 = '{8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h55};
    for (int i = 0; i < 8; i++) begin
      checkOutput("pushpop:data", 64'(tx_data), 64'(exp4[i]));
      applyStimulus(1, 0, 32'h0, 32'h0, 1);
    end
    checkOutput("pushpop:empty", 64'(tx_valid), 64'h0);

    for (int i = 0; i < 3; i++) applyStimulus(1, 1, A_TXD, 32'(8'hC0 + i), 0);
    applyStimulus(1, 1, A_LED, 32'hFF, 0);
    checkOutput("pre_rst:led", 64'(led), 64'hFF);
    applyStimulus(0, 0, 32'h0, 32'h0, 1);
    checkOutput("mid_rst:tx_valid", 64'(tx_valid), 64'h0);
    checkOutput("mid_rst:led", 64'(led), 64'h0);
    checkOutput("mid_rst:bus_err", 64'(bus_err), 64'h0);
    probeRead(A_CLO, "mid_rst:cyc");
    checkOutput("mid_rst:cyc_const", 64'(readData), 64'h0);
    probeRead(32'h40, "mid_rst:ram");
    checkOutput("mid_rst:ram_const", 64'(readData), 64'hDEAD_BEEF);
    applyStimulus(1, 0, 32'h0, 32'h0, 0);
    probeRead(A_CLO, "post_rst:cyc");

    for (int i = 0; i < 16; i++) applyStimulus(1, 1, 32'(i * 4), $urandom, 0);
    applyStimulus(1, 1, 32'hFFC, $urandom, 0);
    probeRead(32'hFFC, "ram:last_word");

    for (int i = 0; i < 400; i++) begin
      a = randAddr();
      rstN = ($urandom_range(0, 199) != 0);
      wr = rstN && ($urandom_range(0, 99) < 55);
      applyStimulus(rstN, wr, a, $urandom, ($urandom_range(0, 99) < 30));
      checkRegs("rnd");
      probeRead(randAddr(), "rnd:read");
      probeRead(A_STA, "rnd:status");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
